load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_LIMIT, default 256, meaning byte size of the data memory window; any access touching an address >= ADDR_LIMIT is an error.
REQ-002 SHALL have parameter ALLOW_MISALIGNED, default 1, meaning 1 = split misaligned accesses, 0 = reject them as errors.
REQ-003 SHALL have ports, in this order:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  core request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- req_size  in  2  00 = word, 01 = half, 10 = byte, 11 = illegal.
- req_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend loads.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  request rejected; qualified by rsp_valid.
- mem_we  out  1  data memory write enable.
- mem_addr  out  32  data memory address.
- mem_wdata  out  32  data memory write data.
- mem_size  out  2  data memory size code.
- mem_unsigned  out  1  data memory extension select.
- mem_rdata  in  32  data memory read data; combinational from mem_addr, mem_size and mem_unsigned.

Function
REQ-004 SHALL accept a request on the clock edge where req_valid && req_ready, registering all req_* fields; req_ready SHALL be high only in IDLE.
REQ-005 SHALL use states IDLE, ACCESS, LD_LO, LD_HI, ST_BYTE, RESP; after RESP the unit SHALL return to IDLE.
REQ-006 SHALL classify an access as misaligned as follows: word when addr[1:0] != 0; half when addr[0] = 1; byte never.
REQ-007 SHALL flag an error when any of these holds: req_size = 11; addr + nbytes - 1 >= ADDR_LIMIT; the access is misaligned and ALLOW_MISALIGNED = 0. An error SHALL issue no memory operation, go IDLE -> RESP, and pulse rsp_valid with rsp_err = 1 and rsp_rdata = 0 in cycle T+1, where T is the acceptance cycle.
REQ-008 SHALL handle an aligned access in ACCESS for exactly one cycle (T+1): mem_* carry the request fields, with mem_we = req_we; rsp_valid SHALL pulse in T+2.
REQ-009 SHALL handle a misaligned load with two memory operations:
- LD_LO reads word addr & ~3, with mem_size = 00.
- LD_HI reads word (addr & ~3) + 4, with mem_size = 00.
- Both words SHALL be captured.
- The 64-bit value {hi, lo} SHALL be shifted right by 8 * addr[1:0], truncated to size and extended per req_unsigned.
- rsp_valid SHALL pulse in T+3.
REQ-010 SHALL handle a misaligned store in ST_BYTE:
- One byte write per cycle, with mem_size = 10 and mem_we = 1.
- Byte i (i = 0 .. nbytes-1) goes to addr + i, with mem_wdata[7:0] = req_wdata byte i.
- A 2-bit counter SHALL sequence the bytes.
- rsp_valid SHALL pulse in the cycle after the last byte write (T+3 for half, T+5 for word).
REQ-011 SHALL pass aligned load data to rsp_rdata as mem_rdata captured at the end of the ACCESS cycle.
REQ-012 SHALL hold rsp_valid high for exactly one cycle per accepted request; there is no backpressure on responses.
REQ-013 SHALL drive mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_size = 00 and mem_unsigned = 0 whenever no memory operation is in progress.
REQ-014 SHALL give address-limit checks on accesses that would wrap past 0xFFFFFFFF the same error result as an out-of-range access.

Reset
REQ-015 SHALL, while reset is high, force state = IDLE, req_ready = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, and all mem_* outputs to the REQ-013 values.
REQ-016 SHALL, on reset mid-operation, abandon the request with no response and leave any byte writes already performed in memory; req_ready SHALL rise in the first cycle after reset deasserts.

Structure
REQ-017 SHALL place the size encoding (SZ_WORD, SZ_HALF, SZ_BYTE), the state enum and a size-to-byte-count function in the shared package lsu_pkg.
REQ-018 SHALL place the shift, truncate and extend merge logic in one combinational sub-module, lsu_load_align, used by both the aligned and the misaligned load paths.

Verification
REQ-019 Aligned word store, then load: store 0x000000F0 <- 0xDEADBEEF, then load word 0x000000F0 -> one mem write in T+1, rsp_valid in T+2, rsp_rdata = 0xDEADBEEF, rsp_err = 0.
REQ-020 Misaligned word load: memory word 0x10 = 0x44332211, word 0x14 = 0x88776655; load word 0x13 -> reads of 0x10 then 0x14, rsp_rdata = 0x77665544 in T+3.
REQ-021 Misaligned half store, then load: store half 0x17 <- 0x0000A5C3 -> byte writes 0xC3 to 0x17 and 0xA5 to 0x18; a later signed half load of 0x17 -> rsp_rdata = 0xFFFFA5C3; unsigned -> 0x0000A5C3.
REQ-022 Error cases: req_size = 11 -> rsp_err = 1 in T+1 with no mem_we; word access at 0xFE with ADDR_LIMIT = 256 -> rsp_err = 1; ALLOW_MISALIGNED = 0 with word access at 0x02 -> rsp_err = 1.
REQ-023 Reset mid-store: assert reset during the second byte of a misaligned word store at 0x21 -> only byte 0x21 written, no rsp_valid, req_ready = 1 in the first cycle after reset deasserts.
REQ-024 Back-to-back traffic: req_valid held high for 3 aligned loads -> req_ready low during ACCESS and RESP, exactly 3 rsp_valid pulses, spaced 3 cycles apart.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size encoding, FSM states and
// small helpers for byte counts and alignment classification.
package lsu_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    LD_LO,
    LD_HI,
    ST_BYTE,
    RESP
  } lsu_state_e;

  // Number of bytes touched by an access; the illegal code counts as one so
  // the range check stays well defined (it is rejected anyway).
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_WORD: return 3'd4;
      SZ_HALF: return 3'd2;
      default: return 3'd1;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
    return ((sz == SZ_WORD) && (a != 2'b00)) || ((sz == SZ_HALF) && a[0]);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data merge: shifts the 64-bit {hi, lo} pair right by whole bytes,
// truncates to the access size and sign/zero extends.
//   lo_i, hi_i  : low and high source words
//   shift_i     : byte offset (0..3)
//   size_i      : size code (word/half/byte)
//   unsigned_i  : 1 = zero-extend, 0 = sign-extend
//   data_o      : extended result
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] lo_i,
  input  logic [31:0] hi_i,
  input  logic [1:0]  shift_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = 32'({hi_i, lo_i} >> {shift_i, 3'b000});
    case (size_i)
      SZ_HALF: data_o = unsigned_i ? {16'h0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
      SZ_BYTE: data_o = unsigned_i ? {24'h0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between a core request port and a single-cycle data memory.
// Aligned accesses take one memory cycle; misaligned loads read two words and
// merge them, misaligned stores are split into byte writes.
//   clk, reset          : clock, synchronous active-high reset
//   req_*               : core request (valid/ready handshake, accepted in IDLE)
//   rsp_valid/rdata/err : one-cycle completion pulse with load data or error
//   mem_*               : data memory port; mem_rdata is combinational
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT       = 256,
  parameter int          ALLOW_MISALIGNED = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  output logic        mem_unsigned,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        err_q, err_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] rdata_q, rdata_d;

  // Request classification. The end address is computed in 33 bits so an
  // access wrapping past 0xFFFFFFFF lands above the limit and is rejected.
  logic [32:0] req_last;
  logic        req_mis;
  logic        req_err;

  always_comb begin
    req_last = {1'b0, req_addr} + 33'(size_bytes(req_size)) - 33'd1;
    req_mis  = is_misaligned(req_size, req_addr[1:0]);
    req_err  = (req_size == SZ_ILL) || (req_last >= 33'(ADDR_LIMIT)) ||
               (req_mis && (ALLOW_MISALIGNED == 0));
  end

  // One merge path serves both load flavours: aligned loads pass mem_rdata
  // with no shift, misaligned loads merge the captured low word with the
  // high word being read in LD_HI.
  logic        in_hi;
  logic [31:0] al_lo, al_hi, al_data;
  logic [1:0]  al_shift;

  assign in_hi    = (state_q == LD_HI);
  assign al_lo    = in_hi ? lo_q : mem_rdata;
  assign al_hi    = in_hi ? mem_rdata : 32'h0;
  assign al_shift = in_hi ? addr_q[1:0] : 2'b00;

  lsu_load_align u_align (
    .lo_i       (al_lo),
    .hi_i       (al_hi),
    .shift_i    (al_shift),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (al_data)
  );

  logic [1:0] last_idx;
  assign last_idx = 2'(size_bytes(size_q) - 3'd1);

  // Next-state and register updates
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          uns_d   = req_unsigned;
          err_d   = req_err;
          cnt_d   = 2'd0;
          lo_d    = 32'h0;
          rdata_d = 32'h0;
          if (req_err)       state_d = RESP;
          else if (!req_mis) state_d = ACCESS;
          else if (req_we)   state_d = ST_BYTE;
          else               state_d = LD_LO;
        end
      end
      ACCESS: begin
        if (!we_q) rdata_d = al_data;
        state_d = RESP;
      end
      LD_LO: begin
        lo_d    = mem_rdata;
        state_d = LD_HI;
      end
      LD_HI: begin
        rdata_d = al_data;
        state_d = RESP;
      end
      ST_BYTE: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == last_idx) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs; reset forces the idle values combinationally so nothing leaks
  // out during the reset cycle itself.
  logic [7:0] st_byte;
  assign st_byte = 8'(wdata_q >> {cnt_q, 3'b000});

  always_comb begin
    req_ready    = (state_q == IDLE);
    rsp_valid    = (state_q == RESP);
    rsp_err      = (state_q == RESP) && err_q;
    rsp_rdata    = (state_q == RESP) ? rdata_q : 32'h0;
    mem_we       = 1'b0;
    mem_addr     = 32'h0;
    mem_wdata    = 32'h0;
    mem_size     = SZ_WORD;
    mem_unsigned = 1'b0;
    case (state_q)
      ACCESS: begin
        mem_we       = we_q;
        mem_addr     = addr_q;
        mem_wdata    = wdata_q;
        mem_size     = size_q;
        mem_unsigned = uns_q;
      end
      LD_LO:   mem_addr = {addr_q[31:2], 2'b00};
      LD_HI:   mem_addr = {addr_q[31:2], 2'b00} + 32'd4;
      ST_BYTE: begin
        mem_we    = 1'b1;
        mem_addr  = addr_q + {30'h0, cnt_q};
        mem_wdata = {24'h0, st_byte};
        mem_size  = SZ_BYTE;
      end
      default: ;
    endcase
    if (reset) begin
      req_ready    = 1'b0;
      rsp_valid    = 1'b0;
      rsp_err      = 1'b0;
      rsp_rdata    = 32'h0;
      mem_we       = 1'b0;
      mem_addr     = 32'h0;
      mem_wdata    = 32'h0;
      mem_size     = SZ_WORD;
      mem_unsigned = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      size_q  <= SZ_WORD;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 2'd0;
      lo_q    <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-array memory drives the DUT's
// memory port, a reference byte array predicts responses and latency, and a
// monitor compares every rsp_valid pulse against the queued expectation.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_we, mem_unsigned;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_size;

  logic        s_req_valid, s_req_ready, s_rsp_valid, s_rsp_err;
  logic [31:0] s_rsp_rdata, s_mem_addr, s_mem_wdata, s_mem_rdata;
  logic        s_mem_we, s_mem_unsigned;
  logic [1:0]  s_mem_size;
  assign s_mem_rdata = 32'h0;

  load_store_unit #(.ADDR_LIMIT(256), .ALLOW_MISALIGNED(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .mem_rdata(mem_rdata)
  );

  load_store_unit #(.ADDR_LIMIT(256), .ALLOW_MISALIGNED(0)) u_strict (
    .clk(clk), .reset(reset),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid(s_rsp_valid), .rsp_rdata(s_rsp_rdata), .rsp_err(s_rsp_err),
    .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_size(s_mem_size), .mem_unsigned(s_mem_unsigned), .mem_rdata(s_mem_rdata)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- physical memory seen by the DUT ----------------
  logic [7:0]  pmem [0:511];
  logic        pl_we;
  logic [8:0]  pl_addr;
  logic [7:0]  pl_data;
  int          wcount = 0;
  logic [8:0]  pa;
  logic [31:0] pw;

  always @(posedge clk) begin
    if (pl_we) pmem[pl_addr] <= pl_data;
    if (mem_we) begin
      wcount <= wcount + 1;
      pmem[mem_addr[8:0]] <= mem_wdata[7:0];
      if (mem_size != 2'b10) pmem[mem_addr[8:0] + 9'd1] <= mem_wdata[15:8];
      if (mem_size == 2'b00) begin
        pmem[mem_addr[8:0] + 9'd2] <= mem_wdata[23:16];
        pmem[mem_addr[8:0] + 9'd3] <= mem_wdata[31:24];
      end
    end
  end

  always_comb begin
    pa = mem_addr[8:0];
    pw = {pmem[pa + 9'd3], pmem[pa + 9'd2], pmem[pa + 9'd1], pmem[pa]};
    case (mem_size)
      2'b01:   mem_rdata = mem_unsigned ? {16'h0, pw[15:0]} : {{16{pw[15]}}, pw[15:0]};
      2'b10:   mem_rdata = mem_unsigned ? {24'h0, pw[7:0]}  : {{24{pw[7]}}, pw[7:0]};
      2'b00:   mem_rdata = pw;
      default: mem_rdata = 32'h0;
    endcase
  end

  // ---------------- reference model ----------------
  logic [7:0] rmem [0:511];

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          t;
  } exp_t;
  exp_t sb [$];

  function automatic int nbytes_of(input logic [1:0] sz);
    return (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
  endfunction

  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] sz, input logic uns, output exp_t e);
    int n;
    longint unsigned last, v;
    bit mis;
    n    = nbytes_of(sz);
    last = longint'({32'h0, addr}) + longint'(n) - 1;
    mis  = ((sz == 2'd0) && (addr % 4 != 0)) || ((sz == 2'd1) && (addr % 2 != 0));
    e.err   = (sz == 2'd3) || (last >= 256);
    e.rdata = 32'h0;
    e.t     = 0;
    if (e.err) e.lat = 1;
    else begin
      e.lat = !mis ? 2 : (we ? 1 + n : 3);
      if (we) begin
        for (int i = 0; i < n; i++) rmem[addr[8:0] + 9'(i)] = 8'(wdata >> (8 * i));
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v = v | (longint'(rmem[addr[8:0] + 9'(i)]) << (8 * i));
        if (!uns && n < 4 && v[8 * n - 1]) v = v | (~64'd0 << (8 * n));
        e.rdata = v[31:0];
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  exp_t m;
  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: rsp_valid with nothing outstanding (cycle %0d)", cyc);
      end else begin
        m = sb.pop_front();
        checks++;
        if (rsp_err !== m.err || rsp_rdata !== m.rdata || (cyc - m.t) != m.lat) begin
          errors++;
          $display("FAIL rsp: got err=%b rdata=%h lat=%0d expected err=%b rdata=%h lat=%0d",
                   rsp_err, rsp_rdata, cyc - m.t, m.err, m.rdata, m.lat);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] sz, input logic uns, input bit track);
    exp_t e;
    int   waited;
    req_we = we; req_addr = addr; req_wdata = wdata; req_size = sz; req_unsigned = uns;
    req_valid = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!req_ready && waited < 50);
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready stayed %b, expected 1", req_ready);
      return;
    end
    if (track) begin
      model(we, addr, wdata, sz, uns, e);
      e.t = cyc;
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_valid = 1'b0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_outstanding", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_mem_bus", {mem_we, mem_unsigned, mem_size, mem_addr[27:0]} | mem_wdata, 32'h0);
    chk("idle_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [8:0] a, input logic [7:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d; rmem[a] = d;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  task automatic strict_req(input logic [31:0] addr, input logic [1:0] sz,
                            input logic exp_err, input int exp_lat);
    int t, n;
    req_we = 1'b0; req_addr = addr; req_wdata = 32'h0; req_size = sz; req_unsigned = 1'b0;
    s_req_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_req_ready && n < 20);
    t = cyc;
    @(posedge clk); #1;
    s_req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_rsp_valid && n < 20);
    chk("strict_valid", {31'h0, s_rsp_valid}, 32'h1);
    chk("strict_err", {31'h0, s_rsp_err}, {31'h0, exp_err});
    chk("strict_rdata", s_rsp_rdata, 32'h0);
    chk("strict_latency", 32'(cyc - t), 32'(exp_lat));
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int w0, nbad;
    reset = 1'b1; req_valid = 1'b0; s_req_valid = 1'b0; pl_we = 1'b0;
    req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_size = 2'b00; req_unsigned = 1'b0;
    pl_addr = 9'h0; pl_data = 8'h0;
    @(posedge clk); #1;
    for (int i = 0; i < 512; i++) preload(9'(i), 8'($urandom));

    // reset state, with a request pending to show it is not accepted
    req_valid = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_size_uns", {29'h0, mem_size, mem_unsigned}, 32'h0);
    chk("rst_strict_ready", {31'h0, s_req_ready}, 32'h0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;

    // aligned word store then load
    w0 = wcount;
    issue(1'b1, 32'hF0, 32'hDEADBEEF, 2'b00, 1'b0, 1'b1);
    drain();
    chk("aligned_store_writes", 32'(wcount - w0), 32'd1);
    issue(1'b0, 32'hF0, 32'h0, 2'b00, 1'b0, 1'b1);
    drain();

    // misaligned word load across 0x10 / 0x14
    for (int i = 0; i < 8; i++) preload(9'(8'h10 + i), 8'(8'h11 * (i + 1)));
    issue(1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 1'b1);
    drain();

    // misaligned half store, signed and unsigned reload
    w0 = wcount;
    issue(1'b1, 32'h17, 32'h0000A5C3, 2'b01, 1'b0, 1'b1);
    drain();
    chk("half_store_writes", 32'(wcount - w0), 32'd2);
    chk("half_store_b0", {24'h0, pmem[9'h17]}, 32'hC3);
    chk("half_store_b1", {24'h0, pmem[9'h18]}, 32'hA5);
    issue(1'b0, 32'h17, 32'h0, 2'b01, 1'b0, 1'b1);
    issue(1'b0, 32'h17, 32'h0, 2'b01, 1'b1, 1'b1);
    drain();

    // error cases: none may touch memory
    w0 = wcount;
    issue(1'b1, 32'h40, 32'h12345678, 2'b11, 1'b0, 1'b1);
    issue(1'b0, 32'hFE, 32'h0, 2'b00, 1'b0, 1'b1);
    issue(1'b1, 32'hFF, 32'h0000FFFF, 2'b01, 1'b0, 1'b1);
    issue(1'b1, 32'hFFFFFFFF, 32'h0000FFFF, 2'b01, 1'b0, 1'b1);
    issue(1'b0, 32'hFFFFFFFC, 32'h0, 2'b00, 1'b0, 1'b1);
    issue(1'b0, 32'hFF, 32'h0, 2'b10, 1'b0, 1'b1);
    drain();
    chk("error_no_writes", 32'(wcount - w0), 32'd0);

    // misaligned accesses rejected when splitting is disabled
    strict_req(32'h02, 2'b00, 1'b1, 1);
    strict_req(32'h01, 2'b01, 1'b1, 1);
    strict_req(32'h04, 2'b00, 1'b0, 2);

    // back-to-back aligned loads with req_valid held high
    issue(1'b0, 32'h20, 32'h0, 2'b00, 1'b0, 1'b1);
    @(negedge clk);
    chk("b2b_ready_access", {31'h0, req_ready}, 32'h0);
    @(negedge clk);
    chk("b2b_ready_resp", {31'h0, req_ready}, 32'h0);
    issue(1'b0, 32'h24, 32'h0, 2'b01, 1'b1, 1'b1);
    issue(1'b0, 32'h2B, 32'h0, 2'b10, 1'b0, 1'b1);
    drain();

    // reset during the second byte of a misaligned word store
    issue(1'b1, 32'h21, 32'h11223344, 2'b00, 1'b0, 1'b0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    w0 = wcount;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    rmem[9'h21] = 8'h44;
    @(negedge clk);
    chk("midrst_ready_after", {31'h0, req_ready}, 32'h1);
    chk("midrst_no_rsp", {31'h0, rsp_valid}, 32'h0);
    chk("midrst_writes", 32'(wcount - w0), 32'd0);
    chk("midrst_byte0", {24'h0, pmem[9'h21]}, 32'h44);
    chk("midrst_byte1_kept", {24'h0, pmem[9'h22]}, {24'h0, rmem[9'h22]});
    @(posedge clk); #1;

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = ($urandom % 8 == 7) ? 2'b11 : 2'($urandom % 3);
      a  = ($urandom % 16 == 0) ? (32'hFFFFFFF0 + 32'($urandom % 16))
                                : 32'($urandom_range(0, 32'h10F));
      issue(1'($urandom), a, $urandom, sz, 1'($urandom), 1'b1);
      if ($urandom % 4 == 0) begin
        req_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    drain();

    nbad = 0;
    for (int i = 0; i < 9'h120; i++) if (pmem[i] !== rmem[i]) nbad++;
    chk("mem_image", 32'(nbad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
